// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: size encodings, FSM state type
// and the alignment rule applied when LSU_ALIGN_CHECK_EN is defined.
// No ports; imported by lsu_lane and lsu_ctrl.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // True when the access cannot be performed as a single naturally aligned
  // access, or uses the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = ofs[0];
      SZ_WORD: bad = (ofs != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian byte-lane logic: load extract/extend and sub-word store merge.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: size/sgn/ofs select the lane; rd_word is the memory word, wdata the
//        right-justified store data; ld_data is the extended load result,
//        st_word the word to write back.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  ofs,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  // Offset 0 is the most significant byte, so the byte's bit position is
  // 8*(3-ofs), and 3-ofs is simply ~ofs for a 2-bit offset.
  logic [4:0]  byte_lsb;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign byte_lsb = {~ofs, 3'b000};
  assign sel_byte = rd_word[byte_lsb +: 8];
  assign sel_half = ofs[1] ? rd_word[15:0] : rd_word[31:16];

  always_comb begin
    ld_data = rd_word;
    st_word = wdata;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{sgn & sel_byte[7]}}, sel_byte};
        st_word = rd_word;
        st_word[byte_lsb +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_data = {{16{sgn & sel_half[15]}}, sel_half};
        st_word = rd_word;
        if (ofs[1]) st_word[15:0]  = wdata[15:0];
        else        st_word[31:16] = wdata[15:0];
      end
      // Word and the reserved code both behave as whole-word accesses here;
      // the reserved code is filtered upstream when alignment checking is on.
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between datapath and d_mem; sub-word stores are read-modify-write.
// Latency accept->done: load 2, word store 2, sub-word store 3, rejected access 1.
// Backpressure: ready low from accept until the cycle after done; req ignored meanwhile.
// Ports: req/ready/we/size/sgn/adr/wdata request side; done/rdata/err completion;
//        mem_adr/mem_din/mem_wren/mem_dout word-wide data memory port.
// Optional: define LSU_ALIGN_CHECK_EN to reject misaligned and reserved-size accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  output logic                  ready,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sgn,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  state_t                state;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  sgn_q;
  logic [1:0]            ofs_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic                  reject;
  logic                  word_store;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] st_word;

`ifdef LSU_ALIGN_CHECK_EN
  assign reject = is_misaligned(size, adr[1:0]);
`else
  assign reject = 1'b0;
`endif

  // size[1] covers both the word code and the reserved code, which is a word
  // access when it is not rejected.
  assign word_store = we & size[1];

  lsu_lane u_lane (
    .size    (size_q),
    .sgn     (sgn_q),
    .ofs     (ofs_q),
    .rd_word (mem_dout),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      err_q   <= 1'b0;
      rdata   <= '0;
      mem_adr <= '0;
      mem_din <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      ofs_q   <= 2'b00;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            sgn_q   <= sgn;
            ofs_q   <= adr[1:0];
            wdata_q <= wdata;
            ready   <= 1'b0;
            if (reject) begin
              // No memory cycle at all: report straight away.
              state <= DONE;
              done  <= 1'b1;
              err_q <= 1'b1;
              rdata <= '0;
            end else begin
              mem_adr <= {adr[ADDR_WIDTH-1:2], 2'b00};
              if (word_store) begin
                state   <= WRITE;
                mem_din <= wdata;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          // mem_dout is valid for the addressed word at the end of this cycle.
          if (we_q) begin
            state   <= WRITE;
            mem_din <= st_word;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            rdata <= ld_data;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
          rdata <= '0;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err_q <= 1'b0;
          rdata <= '0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so a reset landing on the WRITE cycle never commits.
  assign mem_wren = (state == WRITE) && rst_n;
  assign err      = err_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller that sits between the CPU datapath and the data memory (`d_mem`) and initiates every data access. It accepts one byte, halfword or word request at a time over a ready/done handshake. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are performed as read-modify-write, because the data memory only takes whole words.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width; fixed at 32 for lane logic
- ADDR_WIDTH, 32, byte address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  1  access request from datapath; sampled only when ready=1
- ready  out  1  controller idle and able to accept req
- we  in  1  1 = store, 0 = load; captured with req
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved; captured with req
- sgn  in  1  sign-extend sub-word load; captured with req
- adr  in  ADDR_WIDTH  byte address; captured with req
- wdata  in  DATA_WIDTH  store data, right-justified; captured with req
- done  out  1  one-cycle pulse: access complete
- rdata  out  DATA_WIDTH  load result; valid only while done=1, otherwise 0
- err  out  1  access rejected; valid only while done=1
- mem_adr  out  ADDR_WIDTH  word-aligned address to d_mem; low 2 bits always 0
- mem_din  out  DATA_WIDTH  write word to d_mem
- mem_wren  out  1  write enable to d_mem
- mem_dout  in  DATA_WIDTH  read word from d_mem; valid before the next rising edge after mem_adr is stable for one cycle

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- **IDLE:** ready=1. On req=1, capture we/size/sgn/adr/wdata. Next state is:
  - DONE with err, if rejected (see Configuration);
  - WRITE, for a word store;
  - READ, otherwise.
- **READ:** drive mem_adr = {adr[ADDR_WIDTH-1:2],2'b00} and register mem_dout at the end of the cycle. Next state is WRITE for a sub-word store, DONE for a load.
- **WRITE:** mem_wren=1. mem_din is either wdata (word store) or the registered read word with the target lanes replaced. Next state is DONE.
- **DONE:** done=1 and rdata/err driven. Next state is IDLE; ready rises in the following cycle.
- **Byte lanes** are big-endian:
  - byte offset 0 = bits [31:24], offset 3 = bits [7:0];
  - halfword at adr[1]=0 = bits [31:16], adr[1]=1 = bits [15:0].
- **Load extraction:** the selected lane is right-justified, then sign-extended if sgn=1, zero-extended otherwise. Word loads ignore sgn.
- **Store merge:**
  - only the addressed lane takes the low 8/16 bits of wdata;
  - the upper wdata bits are ignored;
  - all other lanes keep the read value.
- req while ready=0 is ignored; the requester must hold req until ready is sampled high.
- mem_wren = (state==WRITE) && rst_n, so no write reaches memory during a reset cycle.

## Timing
- **Reset values:**
  - state=IDLE;
  - ready=1, done=0, err=0;
  - rdata=0, mem_adr=0, mem_din=0, mem_wren=0.
- **Latency from the accept edge to done:**
  - load: 2 cycles (READ, DONE);
  - word store: 2 cycles (WRITE, DONE);
  - sub-word store: 3 cycles (READ, WRITE, DONE);
  - rejected access: 1 cycle.
- Back-to-back throughput: a new req is accepted in the cycle after DONE, i.e. one access per 3–4 cycles.
- Reset mid-operation: rst_n=0 at any edge returns the FSM to IDLE.
  - An in-flight access is abandoned with no done pulse.
  - A WRITE cycle coinciding with rst_n=0 does not write.
- mem_adr holds its value outside READ/WRITE; it is not required to return to 0.

## Configuration
- Macro: LSU_ALIGN_CHECK_EN.
- **Defined:** the following are rejected:
  - halfword with adr[0]=1;
  - word with adr[1:0]≠0;
  - size=11.

  A rejected access makes no memory cycle and produces done=1, err=1, rdata=0.
- **Undefined:**
  - err is tied 0;
  - halfword ignores adr[0]; word ignores adr[1:0];
  - size=11 is treated as word.

## Structure
- **Shared package lsu_pkg:**
  - size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state type/encoding (IDLE, READ, WRITE, DONE).
- **Sub-module lsu_lane:** combinational load extract/extend and store merge, driven by size, sgn, adr[1:0], read word and wdata.
- lsu_ctrl holds the FSM, capture registers and memory-port drive.

## Test plan
- Memory word 0x10 = 0x8899AABB; load byte, adr 0x11, sgn=1 -> done 2 cycles after accept, rdata=0xFFFFFF99, err=0.
- Same word; load half, adr 0x12, sgn=0 -> rdata=0x0000AABB; load word, adr 0x10 -> rdata=0x8899AABB.
- Store byte, wdata=0x123456CC, adr 0x13 -> exactly one mem_wren cycle with mem_din=0x8899AACC; done 3 cycles after accept; subsequent load word reads 0x8899AACC.
- Store word 0xDEADBEEF to adr 0x20 -> no READ cycle, mem_wren for one cycle, done 2 cycles after accept.
- LSU_ALIGN_CHECK_EN defined; load word at adr 0x22 -> done and err=1 1 cycle after accept, rdata=0, mem_wren never high. Undefined: same request reads word 0x20, err=0.
- Sub-word store; rst_n=0 during the WRITE cycle -> mem_wren stays 0, no done pulse, ready=1 after reset, memory word unchanged.
